// File: rtl/store_write_buffer_pkg.sv
// Shared sizing constants and helpers for the posted-store write buffer.
package store_write_buffer_pkg;

    localparam int unsigned SB_DEPTH         = 4;
    localparam int unsigned SB_ADDR_W        = 32;
    localparam int unsigned SB_DATA_W        = 32;
    localparam int unsigned SB_PTR_W         = $clog2(SB_DEPTH);
    localparam int unsigned WORD_OFFSET_BITS = 2;

    function automatic logic is_word_aligned(input logic [WORD_OFFSET_BITS-1:0] offset);
        return offset == '0;
    endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Pipeline-side store/load requests and memory-port signals of the write buffer.
interface store_write_buffer_if #(
    parameter int unsigned ADDR_W = store_write_buffer_pkg::SB_ADDR_W,
    parameter int unsigned DATA_W = store_write_buffer_pkg::SB_DATA_W
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              st_misalign;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_fwd_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, st_misalign, ld_hit, ld_fwd_data,
        input  mem_memread, mem_memwrite, mem_address, mem_write_data, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, st_misalign, ld_hit, ld_fwd_data,
        output mem_memread, mem_memwrite, mem_address, mem_write_data, empty
    );
endinterface

// File: rtl/store_write_buffer_fwd_match.sv
// Load-to-store forwarding: scans entries oldest to youngest from head so the
// youngest matching word address wins.
module sb_fwd_match #(
    parameter int unsigned DEPTH  = store_write_buffer_pkg::SB_DEPTH,
    parameter int unsigned WORD_W = 30,
    parameter int unsigned DATA_W = store_write_buffer_pkg::SB_DATA_W
) (
    input  logic [$clog2(DEPTH)-1:0]       head,
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0][WORD_W-1:0]   word,
    input  logic [DEPTH-1:0][DATA_W-1:0]   data,
    input  logic                           ld_valid,
    input  logic [WORD_W-1:0]              ld_word,
    output logic                           hit_c,
    output logic [DATA_W-1:0]              data_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ld_valid && valid[idx] && (word[idx] == ld_word)) begin
                hit_c  = 1'b1;
                data_c = data[idx];
            end
        end
    end
endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO in front of a combinational data memory; drains one store per
// load-free cycle and forwards buffered data to matching loads.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_write_buffer_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = ADDR_W - WORD_OFFSET_BITS;

    // Entries keep only the word address; the byte offset is always zero.
    logic [DEPTH-1:0][WORD_W-1:0] word_q, word_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         misalign_q, misalign_d;

    logic accept_c, push_c, pop_c, empty_c, ready_c;
    logic fwd_hit_c;
    logic [DATA_W-1:0] fwd_data_c;

    always_comb begin
        empty_c  = (count_q == '0);
        ready_c  = (count_q < CNT_W'(DEPTH));
        accept_c = bus.st_valid && ready_c;
        push_c   = accept_c && is_word_aligned(bus.st_addr[WORD_OFFSET_BITS-1:0]);
        pop_c    = !empty_c && !bus.ld_valid;
    end

    always_comb begin
        word_d     = word_q;
        data_d     = data_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = accept_c && !push_c;
        if (pop_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_c) begin
            word_d[tail_q]  = bus.st_addr[ADDR_W-1:WORD_OFFSET_BITS];
            data_d[tail_q]  = bus.st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .DATA_W (DATA_W)
    ) u_fwd_match (
        .head     (head_q),
        .valid    (valid_q),
        .word     (word_q),
        .data     (data_q),
        .ld_valid (bus.ld_valid),
        .ld_word  (bus.ld_addr[ADDR_W-1:WORD_OFFSET_BITS]),
        .hit_c    (fwd_hit_c),
        .data_c   (fwd_data_c)
    );

    // Memory port: a load always owns the port; otherwise the head drains.
    always_comb begin
        bus.st_ready       = ready_c;
        bus.empty          = empty_c;
        bus.st_misalign    = misalign_q;
        bus.ld_hit         = fwd_hit_c;
        bus.ld_fwd_data    = fwd_data_c;
        bus.mem_memread    = bus.ld_valid;
        bus.mem_memwrite   = pop_c;
        bus.mem_address    = bus.ld_valid ? bus.ld_addr
                                          : {word_q[head_q], WORD_OFFSET_BITS'(0)};
        bus.mem_write_data = pop_c ? data_q[head_q] : '0;
    end
endmodule
